// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - 4-way round-robin arbiter driving the 2-bit select of a 4:1 mux
module mux_sel_arbiter #(
    parameter int CNT_W    = 4,
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       owner_release,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic             HOLD_EN   = (HOLD_MAX != 0);

    state_t           state;
    logic [1:0]       last;
    logic [CNT_W-1:0] hold_cnt;

    logic [1:0] win;
    logic [1:0] idx;
    logic       owner_drop;
    logic       hold_hit;
    logic       grant_exit;

    // Scan from lowest to highest priority so the first set bit after 'last' overwrites all others.
    always_comb begin
        win = 2'd0;
        idx = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    assign owner_drop = !req[sel];
    assign hold_hit   = HOLD_EN && (hold_cnt == HOLD_LAST);
    assign grant_exit = owner_release || owner_drop || hold_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 2'd3;
            hold_cnt  <= '0;
            sel       <= 2'd0;
            gnt       <= 4'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 4'd0) begin
                        sel       <= win;
                        gnt       <= 4'd1 << win;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_exit) begin
                        last      <= sel;
                        gnt       <= 4'd0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        state     <= IDLE;
                        timeout   <= hold_hit && !owner_release && !owner_drop;
                    end else if (hold_cnt != {CNT_W{1'b1}}) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
